// File: rtl/gpr_writeback_pkg.sv
// Shared definitions for the integer register-file write-back slice.
// Build option: WB_BYPASS_EN (see gpr_writeback.sv).
package gpr_writeback_pkg;

    localparam int REG_W      = 5;
    localparam int NUM_GPR    = 32;
    localparam int XLEN       = 64;
    localparam int STARVE_MAX = 4;

    typedef logic [REG_W-1:0] gpr_idx_t;

    // Which source won the write port in a given cycle
    typedef enum logic [1:0] {
        WB_NONE,
        WB_LSU,
        WB_HOLD,
        WB_ALU
    } wb_src_e;

    // x0 is hardwired, so it can never be a hazard
    function automatic logic is_hazard(input logic [NUM_GPR-1:0] busy, input gpr_idx_t idx);
        return (idx != '0) && busy[idx];
    endfunction

endpackage

// File: rtl/gpr_writeback_if.sv
// Bus bundle between execute/LSU/decode and the write-back controller.
// The master side drives results and issue info; the slave is gpr_writeback.
// Build option: WB_BYPASS_EN adds the read-bypass signals.
interface gpr_writeback_if #(
    parameter int XLEN = gpr_writeback_pkg::XLEN
) ();
    import gpr_writeback_pkg::*;

    logic            alu_valid;
    logic            alu_ready;
    gpr_idx_t        alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    gpr_idx_t        lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            iss_valid;
    gpr_idx_t        iss_rd;
    gpr_idx_t        iss_rs1;
    gpr_idx_t        iss_rs2;
    logic            iss_stall;

    logic            rf_wen;
    gpr_idx_t        rf_waddr;
    logic [XLEN-1:0] rf_wdata;

`ifdef WB_BYPASS_EN
    gpr_idx_t        byp_raddr1;
    gpr_idx_t        byp_raddr2;
    logic [XLEN-1:0] byp_rfdata1;
    logic [XLEN-1:0] byp_rfdata2;
    logic [XLEN-1:0] byp_rdata1;
    logic [XLEN-1:0] byp_rdata2;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  iss_stall,
        input  rf_wen, rf_waddr, rf_wdata
`ifdef WB_BYPASS_EN
        ,
        output byp_raddr1, byp_raddr2, byp_rfdata1, byp_rfdata2,
        input  byp_rdata1, byp_rdata2
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  iss_valid, iss_rd, iss_rs1, iss_rs2,
        output iss_stall,
        output rf_wen, rf_waddr, rf_wdata
`ifdef WB_BYPASS_EN
        ,
        input  byp_raddr1, byp_raddr2, byp_rfdata1, byp_rfdata2,
        output byp_rdata1, byp_rdata2
`endif
    );

endinterface

// File: rtl/gpr_scoreboard.sv
// Busy-register scoreboard: one bit per GPR, set at issue, cleared at write-back.
// Lookup uses the registered vector only, so a clear is visible the cycle after.
module gpr_scoreboard
    import gpr_writeback_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en_i,
    input  gpr_idx_t set_idx_i,
    input  logic     clr_en_i,
    input  gpr_idx_t clr_idx_i,
    input  gpr_idx_t rs1_i,
    input  gpr_idx_t rs2_i,
    input  gpr_idx_t rd_i,
    output logic     hit_o
);

    logic [NUM_GPR-1:0] busy_q;
    logic [NUM_GPR-1:0] busy_d;

    // Next busy vector: clear first so a set on the same index wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hit_o = is_hazard(busy_q, rs1_i) ||
                   is_hazard(busy_q, rs2_i) ||
                   is_hazard(busy_q, rd_i);

endmodule

// File: rtl/gpr_writeback.sv
// Write-side controller for the 32 x XLEN integer register file.
// Merges ALU and LSU results onto the single write port (LSU > held ALU > direct ALU),
// parks a losing ALU result in a one-entry hold, bounds LSU starvation of that hold,
// and keeps the busy scoreboard that stalls decode on RAW/WAW.
// Build option WB_BYPASS_EN: adds a write-to-read bypass for two read ports and clears
// the scoreboard at winner selection instead of at the regfile write.
module gpr_writeback #(
    parameter int XLEN       = gpr_writeback_pkg::XLEN,
    parameter int STARVE_MAX = gpr_writeback_pkg::STARVE_MAX
) (
    input logic              clk,
    input logic              rst,
    gpr_writeback_if.slave   wb
);
    import gpr_writeback_pkg::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic             hold_valid_q, hold_valid_d;
    gpr_idx_t         hold_rd_q,    hold_rd_d;
    logic [XLEN-1:0]  hold_data_q,  hold_data_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rf_wen_q,     rf_wen_d;
    gpr_idx_t         rf_waddr_q,   rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q,   rf_wdata_d;

    logic             alu_ready;
    logic             lsu_ready;
    logic             alu_fire;
    logic             lsu_fire;
    wb_src_e          win_src;
    gpr_idx_t         win_rd;
    logic [XLEN-1:0]  win_data;
    logic             stall;
    logic             sb_set;
    logic             sb_clr;
    gpr_idx_t         sb_clr_idx;

    assign alu_ready = !hold_valid_q;
    assign lsu_ready = !(hold_valid_q && (starve_cnt_q == STARVE_LIM));
    assign alu_fire  = wb.alu_valid && alu_ready;
    assign lsu_fire  = wb.lsu_valid && lsu_ready;

    // Pick the single write-port winner for this cycle
    always_comb begin
        win_src  = WB_NONE;
        win_rd   = '0;
        win_data = '0;
        if (lsu_fire) begin
            win_src  = WB_LSU;
            win_rd   = wb.lsu_rd;
            win_data = wb.lsu_data;
        end else if (hold_valid_q) begin
            win_src  = WB_HOLD;
            win_rd   = hold_rd_q;
            win_data = hold_data_q;
        end else if (alu_fire) begin
            win_src  = WB_ALU;
            win_rd   = wb.alu_rd;
            win_data = wb.alu_data;
        end
    end

    // Next state of the hold entry, starvation counter and write stage
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        starve_cnt_d = starve_cnt_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        if (alu_fire && lsu_fire) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = wb.alu_rd;
            hold_data_d  = wb.alu_data;
        end else if (win_src == WB_HOLD) begin
            hold_valid_d = 1'b0;
        end

        if (win_src == WB_HOLD) begin
            starve_cnt_d = '0;
        end else if (lsu_fire && hold_valid_q) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        if (win_src != WB_NONE) begin
            rf_wen_d   = (win_rd != '0);
            rf_waddr_d = win_rd;
            rf_wdata_d = win_data;
        end
    end

    // State registers; reset drops the held result and any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            starve_cnt_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            starve_cnt_q <= starve_cnt_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign sb_set = wb.iss_valid && !stall && (wb.iss_rd != '0);

`ifdef WB_BYPASS_EN
    // With the bypass, a dependent may read the value while it is being written
    assign sb_clr     = rf_wen_d;
    assign sb_clr_idx = win_rd;

    assign wb.byp_rdata1 = (rf_wen_q && (rf_waddr_q == wb.byp_raddr1) && (wb.byp_raddr1 != '0))
                           ? rf_wdata_q : wb.byp_rfdata1;
    assign wb.byp_rdata2 = (rf_wen_q && (rf_waddr_q == wb.byp_raddr2) && (wb.byp_raddr2 != '0))
                           ? rf_wdata_q : wb.byp_rfdata2;
`else
    assign sb_clr     = rf_wen_q;
    assign sb_clr_idx = rf_waddr_q;
`endif

    gpr_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (sb_set),
        .set_idx_i (wb.iss_rd),
        .clr_en_i  (sb_clr),
        .clr_idx_i (sb_clr_idx),
        .rs1_i     (wb.iss_rs1),
        .rs2_i     (wb.iss_rs2),
        .rd_i      (wb.iss_rd),
        .hit_o     (stall)
    );

    assign wb.alu_ready = alu_ready;
    assign wb.lsu_ready = lsu_ready;
    assign wb.iss_stall = stall;
    assign wb.rf_wen    = rf_wen_q;
    assign wb.rf_waddr  = rf_waddr_q;
    assign wb.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_gpr_writeback.sv
// Self-checking bench for gpr_writeback: directed table, hand-written corner sequences
// and a randomized run against a queue/associative-array reference model.
// Build option: WB_BYPASS_EN enables the bypass sequence and bypass checks.
module tb_gpr_writeback;
    import gpr_writeback_pkg::*;

    typedef struct {
        logic        aluValid;
        logic [4:0]  aluRd;
        logic [63:0] aluData;
        logic        lsuValid;
        logic [4:0]  lsuRd;
        logic [63:0] lsuData;
        logic        issValid;
        logic [4:0]  issRd;
        logic [4:0]  issRs1;
        logic [4:0]  issRs2;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        expAluReady;
        logic        expLsuReady;
        logic        expStall;
        logic        expWen;
        logic [4:0]  expWaddr;
        logic [63:0] expWdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } res_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    gpr_writeback_if wbIf ();

    gpr_writeback #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbIf)
    );

    // Reference model state: pending ALU results, LSU grants seen, busy registers,
    // and the write expected on the regfile port after the last edge
    res_t holdQ[$];
    int   starveCount;
    bit   busySet[int];
    bit   lastWen;
    res_t lastWrite;

    logic        sAluRdy, sLsuRdy, sStall, sWen;
    logic [4:0]  sWaddr;
    logic [63:0] sWdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic stim_t mkStim(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                                     input logic lv, input logic [4:0] lr, input logic [63:0] ld,
                                     input logic iv, input logic [4:0] ird,
                                     input logic [4:0] irs1, input logic [4:0] irs2);
        stim_t s;
        s.aluValid = av; s.aluRd = ar; s.aluData = ad;
        s.lsuValid = lv; s.lsuRd = lr; s.lsuData = ld;
        s.issValid = iv; s.issRd = ird; s.issRs1 = irs1; s.issRs2 = irs2;
        return s;
    endfunction

    function automatic stim_t idleStim();
        return mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t mkVec(input stim_t s, input logic ar, input logic lr, input logic st,
                                   input logic w, input logic [4:0] wa, input logic [63:0] wd);
        vec_t v;
        v.s = s; v.expAluReady = ar; v.expLsuReady = lr; v.expStall = st;
        v.expWen = w; v.expWaddr = wa; v.expWdata = wd;
        return v;
    endfunction

    function automatic bit modelBusy(input logic [4:0] r);
        return (r != 0) && busySet.exists(int'(r));
    endfunction

    function automatic bit modelStall(input stim_t s);
        return modelBusy(s.issRs1) || modelBusy(s.issRs2) || modelBusy(s.issRd);
    endfunction

    function automatic bit modelAluReady();
        return holdQ.size() == 0;
    endfunction

    function automatic bit modelLsuReady();
        return !((holdQ.size() != 0) && (starveCount == STARVE_MAX));
    endfunction

    task automatic modelAdvance(input stim_t s, input logic rstIn);
        bit   hadHold;
        bit   lsuGo;
        bit   aluGo;
        bit   stallNow;
        bit   haveWin;
        res_t win;
        if (rstIn) begin
            holdQ.delete();
            starveCount = 0;
            busySet.delete();
            lastWen = 0;
            lastWrite.rd = 0;
            lastWrite.data = 0;
            return;
        end
        hadHold  = holdQ.size() != 0;
        lsuGo    = s.lsuValid && modelLsuReady();
        aluGo    = s.aluValid && modelAluReady();
        stallNow = modelStall(s);
        haveWin  = 0;
        win.rd   = 0;
        win.data = 0;
        if (lsuGo) begin
            win.rd = s.lsuRd; win.data = s.lsuData; haveWin = 1;
            if (aluGo) holdQ.push_back('{s.aluRd, s.aluData});
            if (hadHold) starveCount++;
        end else if (hadHold) begin
            win = holdQ.pop_front(); haveWin = 1;
            starveCount = 0;
        end else if (aluGo) begin
            win.rd = s.aluRd; win.data = s.aluData; haveWin = 1;
        end
`ifdef WB_BYPASS_EN
        if (haveWin && win.rd != 0) busySet.delete(int'(win.rd));
`else
        if (lastWen) busySet.delete(int'(lastWrite.rd));
`endif
        if (s.issValid && !stallNow && s.issRd != 0) busySet[int'(s.issRd)] = 1;
        if (haveWin) begin
            lastWen = (win.rd != 0);
            lastWrite = win;
        end else begin
            lastWen = 0;
        end
    endtask

    // One clock: drive at the falling edge, sample handshakes before the rising edge,
    // sample the write port just after it; every cycle is also checked against the model
    task automatic applyStimulus(input stim_t s, input logic rstIn,
                                 output logic aluRdy, output logic lsuRdy, output logic stall,
                                 output logic wen, output logic [4:0] waddr, output logic [63:0] wdata);
        @(negedge clk);
        rst            = rstIn;
        wbIf.alu_valid = s.aluValid; wbIf.alu_rd = s.aluRd; wbIf.alu_data = s.aluData;
        wbIf.lsu_valid = s.lsuValid; wbIf.lsu_rd = s.lsuRd; wbIf.lsu_data = s.lsuData;
        wbIf.iss_valid = s.issValid; wbIf.iss_rd = s.issRd;
        wbIf.iss_rs1   = s.issRs1;   wbIf.iss_rs2 = s.issRs2;
        #1;
        aluRdy = wbIf.alu_ready;
        lsuRdy = wbIf.lsu_ready;
        stall  = wbIf.iss_stall;
        checkOutput("model alu_ready", aluRdy, modelAluReady());
        checkOutput("model lsu_ready", lsuRdy, modelLsuReady());
        checkOutput("model iss_stall", stall, modelStall(s));
`ifdef WB_BYPASS_EN
        checkOutput("model byp_rdata1", wbIf.byp_rdata1,
                    (lastWen && lastWrite.rd == wbIf.byp_raddr1 && wbIf.byp_raddr1 != 0)
                    ? lastWrite.data : wbIf.byp_rfdata1);
        checkOutput("model byp_rdata2", wbIf.byp_rdata2,
                    (lastWen && lastWrite.rd == wbIf.byp_raddr2 && wbIf.byp_raddr2 != 0)
                    ? lastWrite.data : wbIf.byp_rfdata2);
`endif
        modelAdvance(s, rstIn);
        @(posedge clk);
        #1;
        wen   = wbIf.rf_wen;
        waddr = wbIf.rf_waddr;
        wdata = wbIf.rf_wdata;
        checkOutput("model rf_wen", wen, lastWen);
        if (lastWen) begin
            checkOutput("model rf_waddr", waddr, lastWrite.rd);
            checkOutput("model rf_wdata", wdata, lastWrite.data);
        end
    endtask

    vec_t vecs[16];

    initial begin
        stim_t s;
        rst = 1'b1;
        wbIf.alu_valid = 0; wbIf.alu_rd = 0; wbIf.alu_data = 0;
        wbIf.lsu_valid = 0; wbIf.lsu_rd = 0; wbIf.lsu_data = 0;
        wbIf.iss_valid = 0; wbIf.iss_rd = 0; wbIf.iss_rs1 = 0; wbIf.iss_rs2 = 0;
`ifdef WB_BYPASS_EN
        wbIf.byp_raddr1 = 0; wbIf.byp_raddr2 = 0;
        wbIf.byp_rfdata1 = 0; wbIf.byp_rfdata2 = 0;
`endif
        starveCount = 0; lastWen = 0; lastWrite.rd = 0; lastWrite.data = 0;

        // Directed table: write ordering, hold, starvation limit, rd=0 results
        vecs[0]  = mkVec(mkStim(1, 5, 64'h1234, 0, 0, 0,      0, 0, 0, 0), 1, 1, 0, 1, 5,  64'h1234);
        vecs[1]  = mkVec(mkStim(1, 3, 64'h33,   1, 7, 64'h77, 0, 0, 0, 0), 1, 1, 0, 1, 7,  64'h77);
        vecs[2]  = mkVec(mkStim(0, 0, 0,        0, 0, 0,      1, 0, 5, 6), 0, 1, 0, 1, 3,  64'h33);
        vecs[3]  = mkVec(idleStim(),                                      1, 1, 0, 0, 0,  0);
        vecs[4]  = mkVec(mkStim(1, 10, 64'hA0,  1, 11, 64'hB1, 0, 0, 0, 0), 1, 1, 0, 1, 11, 64'hB1);
        vecs[5]  = mkVec(mkStim(1, 20, 64'hE0,  1, 12, 64'hC2, 0, 0, 0, 0), 0, 1, 0, 1, 12, 64'hC2);
        vecs[6]  = mkVec(mkStim(1, 20, 64'hE0,  1, 13, 64'hC3, 0, 0, 0, 0), 0, 1, 0, 1, 13, 64'hC3);
        vecs[7]  = mkVec(mkStim(1, 20, 64'hE0,  1, 14, 64'hC4, 0, 0, 0, 0), 0, 1, 0, 1, 14, 64'hC4);
        vecs[8]  = mkVec(mkStim(1, 20, 64'hE0,  1, 15, 64'hC5, 0, 0, 0, 0), 0, 1, 0, 1, 15, 64'hC5);
        vecs[9]  = mkVec(mkStim(1, 20, 64'hE0,  1, 16, 64'hD6, 0, 0, 0, 0), 0, 0, 0, 1, 10, 64'hA0);
        vecs[10] = mkVec(mkStim(1, 20, 64'hE0,  1, 16, 64'hD6, 0, 0, 0, 0), 1, 1, 0, 1, 16, 64'hD6);
        vecs[11] = mkVec(idleStim(),                                      0, 1, 0, 1, 20, 64'hE0);
        vecs[12] = mkVec(mkStim(1, 0, 64'hFF,   0, 0, 0,      0, 0, 0, 0), 1, 1, 0, 0, 0,  0);
        vecs[13] = mkVec(mkStim(1, 21, 64'h21,  1, 0, 64'hEE, 0, 0, 0, 0), 1, 1, 0, 0, 0,  0);
        vecs[14] = mkVec(idleStim(),                                      0, 1, 0, 1, 21, 64'h21);
        vecs[15] = mkVec(mkStim(0, 0, 0,        0, 0, 0,      1, 0, 0, 0), 1, 1, 0, 0, 0,  0);

        // Reset and reset-state checks
        applyStimulus(idleStim(), 1, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        applyStimulus(idleStim(), 1, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("reset rf_wen", sWen, 0);
        checkOutput("reset rf_waddr", sWaddr, 0);
        checkOutput("reset rf_wdata", sWdata, 0);
        checkOutput("reset alu_ready", wbIf.alu_ready, 1);
        checkOutput("reset lsu_ready", wbIf.lsu_ready, 1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].s, 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
            checkOutput($sformatf("vec%0d alu_ready", i), sAluRdy, vecs[i].expAluReady);
            checkOutput($sformatf("vec%0d lsu_ready", i), sLsuRdy, vecs[i].expLsuReady);
            checkOutput($sformatf("vec%0d iss_stall", i), sStall, vecs[i].expStall);
            checkOutput($sformatf("vec%0d rf_wen", i), sWen, vecs[i].expWen);
            if (vecs[i].expWen) begin
                checkOutput($sformatf("vec%0d rf_waddr", i), sWaddr, vecs[i].expWaddr);
                checkOutput($sformatf("vec%0d rf_wdata", i), sWdata, vecs[i].expWdata);
            end
        end

        // Scoreboard: RAW/WAW on x9, x0 never stalls, release timing
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 9, 1, 2), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("sb issue rd9 stall", sStall, 0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0, 9, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("sb raw rs1=9 stall", sStall, 1);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 9, 0, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("sb waw rd=9 stall", sStall, 1);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("sb x0 only stall", sStall, 0);
        applyStimulus(mkStim(1, 9, 64'h99, 0, 0, 0, 1, 0, 9, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("sb stall at result", sStall, 1);
        checkOutput("sb write x9 wen", sWen, 1);
        checkOutput("sb write x9 addr", sWaddr, 9);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0, 9, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
`ifdef WB_BYPASS_EN
        checkOutput("sb stall on wen cycle", sStall, 0);
`else
        checkOutput("sb stall on wen cycle", sStall, 1);
`endif
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0, 9, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("sb stall after wen", sStall, 0);

        // Reset with a held ALU result and a busy register
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 4, 0, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        applyStimulus(mkStim(1, 3, 64'h3333, 1, 7, 64'h7777, 0, 0, 0, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("rst-seq lsu write addr", sWaddr, 7);
        applyStimulus(idleStim(), 1, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("rst-seq hold before reset", sAluRdy, 0);
        checkOutput("rst-seq rf_wen after reset", sWen, 0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0, 4, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("rst-seq alu_ready", sAluRdy, 1);
        checkOutput("rst-seq busy4 cleared", sStall, 0);
        checkOutput("rst-seq held not written", sWen, 0);
        applyStimulus(idleStim(), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("rst-seq still no write", sWen, 0);

`ifdef WB_BYPASS_EN
        // Bypass: forward in-flight write data only for a matching nonzero address
        wbIf.byp_raddr1 = 2; wbIf.byp_rfdata1 = 64'h55;
        wbIf.byp_raddr2 = 0; wbIf.byp_rfdata2 = 64'h66;
        applyStimulus(mkStim(1, 2, 64'hAA, 0, 0, 0, 0, 0, 0, 0), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("byp rdata1 forwarded", wbIf.byp_rdata1, 64'hAA);
        checkOutput("byp rdata2 x0 passthru", wbIf.byp_rdata2, 64'h66);
        applyStimulus(idleStim(), 0, sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        checkOutput("byp rdata1 no write", wbIf.byp_rdata1, 64'h55);
`endif

        // Randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            s = mkStim($urandom_range(0, 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                       ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                       $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
`ifdef WB_BYPASS_EN
            wbIf.byp_raddr1 = 5'($urandom_range(0, 7)); wbIf.byp_rfdata1 = {$urandom, $urandom};
            wbIf.byp_raddr2 = 5'($urandom_range(0, 7)); wbIf.byp_rfdata2 = {$urandom, $urandom};
`endif
            applyStimulus(s, ($urandom_range(0, 199) == 0), sAluRdy, sLsuRdy, sStall, sWen, sWaddr, sWdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
